// File: rtl/eth_parser_pkg.sv
// Shared types and constants for the GMII receive frame parser.
package eth_parser_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DST_MAC,
    ST_SRC_MAC,
    ST_TYPE,
    ST_VLAN_TCI,
    ST_PAYLOAD,
    ST_DROP
  } parser_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [15:0] VLAN_TPID     = 16'h8100;

  localparam int MAC_BYTES  = 6;
  localparam int TYPE_BYTES = 2;

  // True when a byte cannot be part of the preamble.
  function automatic logic preamble_error(input logic [7:0] b);
    return b != PREAMBLE_BYTE;
  endfunction

  // True when a byte is not the start-of-frame delimiter.
  function automatic logic sfd_error(input logic [7:0] b);
    return b != SFD_BYTE;
  endfunction

endpackage

// File: rtl/eth_payload_skid.sv
// One-byte holding register between the parser and the payload port.
// The byte is held for one cycle so that the end of the frame (rx_valid
// falling) is known before the byte leaves, which is what lets the final
// byte carry payload_last.
module eth_payload_skid (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_end,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last
);

  logic       hold_vld;
  logic [7:0] hold_data;

  // Capture stage: remember the byte accepted this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
    end else begin
      hold_vld <= in_valid;
      if (in_valid) hold_data <= in_data;
    end
  end

  // Output stage: release the held byte, tagged last when the frame ended cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= hold_vld;
      out_data  <= hold_vld ? hold_data : '0;
      out_last  <= hold_vld & in_end;
    end
  end

endmodule

// File: rtl/eth_frame_parser.sv
// Byte-serial GMII receive parser: walks preamble/SFD/MACs/VLAN tags/EtherType,
// latches header fields, streams payload+FCS and reports per-frame status.
//
// Stream semantics: rx_valid/rx_data and payload_valid/payload_data are
// valid-only streams with no back-pressure; a byte is transferred on every
// rising clk edge where its valid is high, and the receiver must always accept.
module eth_frame_parser
  import eth_parser_pkg::*;
#(
  parameter int PREAMBLE_LEN  = 7,
  parameter int MAX_VLAN_TAGS = 2,
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int LEN_W         = $clog2(MAX_FRAME_LEN + 4*MAX_VLAN_TAGS + 2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic [47:0]          dst_mac,
  output logic [47:0]          src_mac,
  output logic [15:0]          ether_type,
  output logic [1:0]           vlan_cnt,
  output logic [16*((MAX_VLAN_TAGS > 0) ? MAX_VLAN_TAGS : 1)-1:0] vlan_tci,
  output logic                 hdr_valid,
  output logic                 payload_valid,
  output logic [7:0]           payload_data,
  output logic                 payload_last,
  output logic                 frame_done,
  output logic [LEN_W-1:0]     frame_len,
  output logic                 err_preamble,
  output logic                 err_sfd,
  output logic                 err_incomplete,
  output logic                 err_runt,
  output logic                 err_giant,
  output parser_state_e        dbg_state
);

  localparam int         TCI_SLOTS = (MAX_VLAN_TAGS > 0) ? MAX_VLAN_TAGS : 1;
  localparam logic [1:0] TAG_LIMIT = 2'(MAX_VLAN_TAGS);
  localparam logic [7:0] PRE_LAST  = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] MAC_LAST  = 8'(MAC_BYTES - 1);
  localparam logic [7:0] TYPE_LAST = 8'(TYPE_BYTES - 1);

  parser_state_e state;
  logic [7:0]    cnt;
  logic [1:0]    tag_cnt;
  logic [7:0]    hi_byte;
  logic          rx_valid_q;
  logic          flag_pre;
  logic          flag_sfd;
  logic          flag_giant;

  logic [LEN_W-1:0] len_inc;
  logic [LEN_W:0]   len_limit;
  logic             over_limit;
  logic             fwd_valid;
  logic             fwd_end;
  logic             in_header;

  assign dbg_state = state;

  // Length arithmetic and payload forwarding decisions for the current byte.
  always_comb begin
    len_inc    = (frame_len == '1) ? frame_len : frame_len + LEN_W'(1);
    len_limit  = (LEN_W+1)'(MAX_FRAME_LEN) + ((LEN_W+1)'(tag_cnt) << 2);
    over_limit = {1'b0, len_inc} > len_limit;
    fwd_valid  = (state == ST_PAYLOAD) && rx_valid && !over_limit;
    fwd_end    = (state == ST_PAYLOAD) && !rx_valid;
    in_header  = state inside {ST_PREAMBLE, ST_SFD, ST_DST_MAC, ST_SRC_MAC,
                               ST_TYPE, ST_VLAN_TCI};
  end

  // Parser FSM with header field registers and end-of-frame status.
  // rx_valid_q resets high so that a reset in the middle of an active
  // rx_valid burst makes the tail of that burst go to DROP instead of
  // being mistaken for a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      tag_cnt        <= '0;
      hi_byte        <= '0;
      rx_valid_q     <= 1'b1;
      flag_pre       <= 1'b0;
      flag_sfd       <= 1'b0;
      flag_giant     <= 1'b0;
      dst_mac        <= '0;
      src_mac        <= '0;
      ether_type     <= '0;
      vlan_cnt       <= '0;
      vlan_tci       <= '0;
      hdr_valid      <= 1'b0;
      frame_done     <= 1'b0;
      frame_len      <= '0;
      err_preamble   <= 1'b0;
      err_sfd        <= 1'b0;
      err_incomplete <= 1'b0;
      err_runt       <= 1'b0;
      err_giant      <= 1'b0;
    end else begin
      rx_valid_q     <= rx_valid;
      hdr_valid      <= 1'b0;
      frame_done     <= 1'b0;
      err_preamble   <= 1'b0;
      err_sfd        <= 1'b0;
      err_incomplete <= 1'b0;
      err_runt       <= 1'b0;
      err_giant      <= 1'b0;

      if (!rx_valid) begin
        if (state != ST_IDLE) begin
          frame_done     <= 1'b1;
          err_preamble   <= flag_pre;
          err_sfd        <= flag_sfd;
          err_giant      <= flag_giant;
          err_incomplete <= in_header;
          err_runt       <= (state == ST_PAYLOAD) &&
                            (frame_len < LEN_W'(MIN_FRAME_LEN));
          flag_pre       <= 1'b0;
          flag_sfd       <= 1'b0;
          flag_giant     <= 1'b0;
          state          <= ST_IDLE;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            frame_len <= '0;
            tag_cnt   <= '0;
            cnt       <= 8'd1;
            if (rx_valid_q || preamble_error(rx_data)) begin
              flag_pre <= 1'b1;
              state    <= ST_DROP;
            end else if (PREAMBLE_LEN <= 1) begin
              state <= ST_SFD;
            end else begin
              state <= ST_PREAMBLE;
            end
          end
          ST_PREAMBLE: begin
            if (preamble_error(rx_data)) begin
              flag_pre <= 1'b1;
              state    <= ST_DROP;
            end else if (cnt == PRE_LAST) begin
              state <= ST_SFD;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          ST_SFD: begin
            cnt <= '0;
            if (sfd_error(rx_data)) begin
              flag_sfd <= 1'b1;
              state    <= ST_DROP;
            end else begin
              frame_len <= '0;
              state     <= ST_DST_MAC;
            end
          end
          ST_DST_MAC: begin
            frame_len <= len_inc;
            dst_mac   <= {dst_mac[39:0], rx_data};
            if (cnt == MAC_LAST) begin
              cnt   <= '0;
              state <= ST_SRC_MAC;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          ST_SRC_MAC: begin
            frame_len <= len_inc;
            src_mac   <= {src_mac[39:0], rx_data};
            if (cnt == MAC_LAST) begin
              cnt   <= '0;
              state <= ST_TYPE;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          ST_TYPE: begin
            frame_len <= len_inc;
            if (cnt != TYPE_LAST) begin
              hi_byte <= rx_data;
              cnt     <= cnt + 8'd1;
            end else begin
              cnt <= '0;
              if ({hi_byte, rx_data} == VLAN_TPID && tag_cnt < TAG_LIMIT) begin
                state <= ST_VLAN_TCI;
              end else begin
                ether_type <= {hi_byte, rx_data};
                vlan_cnt   <= tag_cnt;
                hdr_valid  <= 1'b1;
                state      <= ST_PAYLOAD;
              end
            end
          end
          ST_VLAN_TCI: begin
            frame_len <= len_inc;
            if (cnt == 8'd0) begin
              hi_byte <= rx_data;
              cnt     <= 8'd1;
            end else begin
              for (int i = 0; i < TCI_SLOTS; i++) begin
                if (tag_cnt == 2'(i)) vlan_tci[16*i +: 16] <= {hi_byte, rx_data};
              end
              tag_cnt <= tag_cnt + 2'd1;
              cnt     <= '0;
              state   <= ST_TYPE;
            end
          end
          ST_PAYLOAD: begin
            frame_len <= len_inc;
            if (over_limit) begin
              flag_giant <= 1'b1;
              state      <= ST_DROP;
            end
          end
          ST_DROP: begin
            state <= ST_DROP;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  eth_payload_skid u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (fwd_valid),
    .in_data   (rx_data),
    .in_end    (fwd_end),
    .out_valid (payload_valid),
    .out_data  (payload_data),
    .out_last  (payload_last)
  );

endmodule

// File: tb/tb_eth_frame_parser.sv
// Self-checking bench for eth_frame_parser: directed and random frames are
// compared against a byte-array reference model of the frame format.
module tb_eth_frame_parser;
  import eth_parser_pkg::*;

  localparam int PRE_LEN  = 7;
  localparam int MAX_TAGS = 2;
  localparam int MIN_LEN  = 64;
  localparam int MAX_LEN  = 1518;

  // clock / reset
  logic clk;
  logic rst_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic          rx_valid;
  logic [7:0]    rx_data;
  logic [47:0]   dst_mac, src_mac;
  logic [15:0]   ether_type;
  logic [1:0]    vlan_cnt;
  logic [31:0]   vlan_tci;
  logic          hdr_valid, payload_valid, payload_last, frame_done;
  logic [7:0]    payload_data;
  logic [10:0]   frame_len;
  logic          err_preamble, err_sfd, err_incomplete, err_runt, err_giant;
  parser_state_e dbg_state;

  eth_frame_parser dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .dst_mac        (dst_mac),
    .src_mac        (src_mac),
    .ether_type     (ether_type),
    .vlan_cnt       (vlan_cnt),
    .vlan_tci       (vlan_tci),
    .hdr_valid      (hdr_valid),
    .payload_valid  (payload_valid),
    .payload_data   (payload_data),
    .payload_last   (payload_last),
    .frame_done     (frame_done),
    .frame_len      (frame_len),
    .err_preamble   (err_preamble),
    .err_sfd        (err_sfd),
    .err_incomplete (err_incomplete),
    .err_runt       (err_runt),
    .err_giant      (err_giant),
    .dbg_state      (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // monitor captures (sampled on the falling edge)
  int          hdr_cnt, done_cnt, last_cnt;
  bit          last_at_done;
  logic [47:0] cap_dst, cap_src;
  logic [15:0] cap_type;
  logic [1:0]  cap_vcnt;
  logic [31:0] cap_tci;
  logic [10:0] cap_len;
  bit          cap_pre, cap_sfd, cap_inc, cap_runt, cap_giant;
  logic [7:0]  got_pl[$];

  task automatic clear_monitor();
    hdr_cnt = 0; done_cnt = 0; last_cnt = 0; last_at_done = 0;
    got_pl = {};
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (hdr_valid) begin
        hdr_cnt++;
        cap_dst = dst_mac; cap_src = src_mac; cap_type = ether_type;
        cap_vcnt = vlan_cnt; cap_tci = vlan_tci;
      end
      if (payload_valid) got_pl.push_back(payload_data);
      if (payload_last) last_cnt++;
      if (frame_done) begin
        done_cnt++;
        last_at_done = payload_last;
        cap_len = frame_len;
        cap_pre = err_preamble; cap_sfd = err_sfd; cap_inc = err_incomplete;
        cap_runt = err_runt; cap_giant = err_giant;
      end
    end
  end

  // reference model: expected outcome of the byte list in frm
  logic [7:0]  frm[$];
  logic [7:0]  exp_q[$];
  bit          exp_hdr, exp_last, exp_len_chk;
  bit          e_pre, e_sfd, e_inc, e_runt, e_giant;
  logic [47:0] exp_dst, exp_src;
  logic [15:0] exp_type;
  logic [15:0] exp_tci[3];
  int          exp_vcnt, exp_len;

  task automatic model_frame(input bit fresh);
    int n, off, blen, pos, tags, limit, stop;
    logic [15:0] t;
    exp_hdr = 0; exp_last = 0; exp_len_chk = 0; exp_len = 0; exp_q = {};
    e_pre = 0; e_sfd = 0; e_inc = 0; e_runt = 0; e_giant = 0;
    exp_dst = '0; exp_src = '0; exp_type = '0; exp_vcnt = 0;
    n = frm.size();
    if (!fresh) begin e_pre = 1; return; end
    for (int i = 0; i < PRE_LEN; i++) begin
      if (i >= n) begin e_inc = 1; return; end
      if (frm[i] != 8'h55) begin e_pre = 1; return; end
    end
    if (n == PRE_LEN) begin e_inc = 1; return; end
    if (frm[PRE_LEN] != 8'hD5) begin e_sfd = 1; return; end
    off = PRE_LEN + 1;
    blen = n - off;
    exp_len = blen; exp_len_chk = 1;
    if (blen < 12) begin e_inc = 1; return; end
    for (int i = 0; i < 6; i++) begin
      exp_dst = {exp_dst[39:0], frm[off+i]};
      exp_src = {exp_src[39:0], frm[off+6+i]};
    end
    pos = 12; tags = 0;
    forever begin
      if (blen < pos + 2) begin e_inc = 1; return; end
      t = {frm[off+pos], frm[off+pos+1]};
      pos += 2;
      if (t != 16'h8100 || tags >= MAX_TAGS) break;
      if (blen < pos + 2) begin e_inc = 1; return; end
      exp_tci[tags] = {frm[off+pos], frm[off+pos+1]};
      tags++;
      pos += 2;
    end
    exp_hdr = 1; exp_type = t; exp_vcnt = tags;
    limit = MAX_LEN + 4 * tags;
    stop = blen;
    if (blen > limit) begin
      e_giant = 1; exp_len_chk = 0; stop = limit;
    end else begin
      e_runt = (blen < MIN_LEN);
    end
    for (int i = pos; i < stop; i++) exp_q.push_back(frm[off+i]);
    exp_last = !e_giant && (stop > pos);
  endtask

  // driver tasks
  task automatic drive_byte(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic build_frame(input logic [47:0] d, input logic [47:0] s, input int ntags,
                             input logic [15:0] t0, input logic [15:0] t1, input logic [15:0] t2,
                             input logic [15:0] et, input int total);
    logic [15:0] tcis[3];
    tcis[0] = t0; tcis[1] = t1; tcis[2] = t2;
    frm = {};
    repeat (PRE_LEN) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int i = 0; i < 6; i++) frm.push_back(d[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(s[47-8*i -: 8]);
    for (int i = 0; i < ntags; i++) begin
      frm.push_back(8'h81); frm.push_back(8'h00);
      frm.push_back(tcis[i][15:8]); frm.push_back(tcis[i][7:0]);
    end
    frm.push_back(et[15:8]); frm.push_back(et[7:0]);
    while (frm.size() < total + PRE_LEN + 1) frm.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic truncate(input int k);
    while (frm.size() > k) void'(frm.pop_back());
  endtask

  // scoreboard: wait for the end-of-frame pulse, then compare everything
  task automatic wait_and_check();
    int n = 0;
    int e0;
    while (done_cnt == 0 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    check("done_cnt", done_cnt, 1);
    check("err_preamble", cap_pre, e_pre);
    check("err_sfd", cap_sfd, e_sfd);
    check("err_incomplete", cap_inc, e_inc);
    check("err_runt", cap_runt, e_runt);
    check("err_giant", cap_giant, e_giant);
    if (exp_len_chk) check("frame_len", cap_len, exp_len);
    check("hdr_cnt", hdr_cnt, exp_hdr);
    if (exp_hdr && hdr_cnt == 1) begin
      check("dst_mac", cap_dst, exp_dst);
      check("src_mac", cap_src, exp_src);
      check("ether_type", cap_type, exp_type);
      check("vlan_cnt", cap_vcnt, exp_vcnt);
      for (int i = 0; i < exp_vcnt; i++) check("vlan_tci", cap_tci[16*i +: 16], exp_tci[i]);
    end
    check("pl_count", got_pl.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_pl.size(); i++) begin
      e0 = errors;
      check("pl_byte", got_pl[i], exp_q[i]);
      if (errors != e0) break;
    end
    check("last_cnt", last_cnt, exp_last);
    check("last_at_done", last_at_done, exp_last);
    clear_monitor();
  endtask

  task automatic run_frame(input int gap);
    model_frame(1'b1);
    foreach (frm[i]) drive_byte(1'b1, frm[i]);
    drive_byte(1'b0, 8'h00);
    wait_and_check();
    repeat (gap) drive_byte(1'b0, 8'h00);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [47:0] d, s;
    logic [15:0] et;
    int ntags, total, sel, err;
    logic [7:0] b;

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0;
    clear_monitor();
    repeat (3) @(posedge clk);
    #1;
    check("rst_dst_mac", dst_mac, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_payload_valid", payload_valid, 0);
    check("rst_hdr_valid", hdr_valid, 0);
    check("rst_frame_len", frame_len, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    repeat (2) drive_byte(1'b0, 8'h00);

    // minimum frame
    build_frame(48'h0102_0304_0506, 48'hA1A2_A3A4_A5A6, 0, 0, 0, 0, 16'h0800, 64);
    run_frame(0);
    // double-tagged, at the tagged size limit
    build_frame(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 2, 16'h0005, 16'h0FFF, 0, 16'h86DD, 1526);
    run_frame(1);
    // third tag falls into the payload
    build_frame(48'h1234_5678_9ABC, 48'h0A0B_0C0D_0E0F, 3, 16'h0123, 16'h0456, 16'h0789, 16'h0800, 100);
    run_frame(0);
    // corrupt 4th preamble byte
    build_frame(48'h1, 48'h2, 0, 0, 0, 0, 16'h0800, 80);
    frm[3] = 8'h54;
    run_frame(0);
    // drop after 3 source MAC bytes
    build_frame(48'h3, 48'h4, 0, 0, 0, 0, 16'h0800, 80);
    truncate(PRE_LEN + 1 + 9);
    run_frame(0);
    // runt
    build_frame(48'h5, 48'h6, 0, 0, 0, 0, 16'h0800, 60);
    run_frame(0);
    // giant
    build_frame(48'h7, 48'h8, 0, 0, 0, 0, 16'h0800, 1600);
    run_frame(0);

    // randomized frames
    for (int f = 0; f < 24; f++) begin
      d = {16'($urandom), 32'($urandom)};
      s = {16'($urandom), 32'($urandom)};
      ntags = $urandom_range(0, 3);
      et = ($urandom_range(0, 1) == 1) ? 16'h0800 : 16'($urandom_range(0, 65535));
      sel = $urandom_range(0, 9);
      if (sel == 0)      total = $urandom_range(1400, 1620);
      else if (sel < 3)  total = $urandom_range(20, 63);
      else               total = $urandom_range(64, 300);
      build_frame(d, s, ntags, 16'($urandom), 16'($urandom), 16'($urandom), et, total);
      err = $urandom_range(0, 9);
      if (err == 0) begin
        b = 8'($urandom_range(0, 255));
        frm[$urandom_range(0, PRE_LEN)] = b;
      end else if (err == 1) begin
        truncate($urandom_range(1, frm.size() - 1));
      end
      run_frame($urandom_range(0, 2));
    end

    // asynchronous reset mid-payload
    build_frame(48'hDEAD_BEEF_0001, 48'hCAFE_F00D_0002, 0, 0, 0, 0, 16'h0800, 200);
    for (int i = 0; i < 60; i++) drive_byte(1'b1, frm[i]);
    rst_n = 1'b0;
    #1;
    check("rstmid_payload_valid", payload_valid, 0);
    check("rstmid_payload_data", payload_data, 0);
    check("rstmid_dst_mac", dst_mac, 0);
    check("rstmid_ether_type", ether_type, 0);
    check("rstmid_frame_len", frame_len, 0);
    check("rstmid_state", dbg_state, ST_IDLE);
    clear_monitor();
    for (int i = 60; i < 63; i++) drive_byte(1'b1, frm[i]);
    rst_n = 1'b1;
    for (int i = 63; i < 80; i++) drive_byte(1'b1, frm[i]);
    model_frame(1'b0);
    drive_byte(1'b0, 8'h00);
    wait_and_check();
    // back-to-back frame after the aborted tail
    build_frame(48'h0A0A_0B0B_0C0C, 48'h0D0D_0E0E_0F0F, 1, 16'h0042, 0, 0, 16'h0806, 90);
    run_frame(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
